// File: rtl/track_ca_generator_pkg.sv
// Shared GPS L1 C/A tracking definitions: code length, FSM state type and
// the G2 phase-select (tap pair) table indexed by PRN.
package track_ca_generator_pkg;

    localparam int unsigned CA_LEN     = 1023;
    localparam int unsigned CHIP_IDX_W = 10;
    localparam int unsigned PRN_W      = 6;
    localparam int unsigned TAP_W      = 4;

    localparam logic [CHIP_IDX_W-1:0] LAST_CHIP = CHIP_IDX_W'(CA_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRELOAD = 2'd1,
        ST_RUN     = 2'd2
    } ca_state_t;

    // G2 stage numbers (1..10) whose XOR forms the delayed G2 output.
    typedef struct packed {
        logic [TAP_W-1:0] a;
        logic [TAP_W-1:0] b;
    } tap_pair_t;

    // 32-entry G2 tap-pair table; out-of-table PRNs fall back to PRN 1.
    function automatic tap_pair_t g2_tap_lookup(input logic [PRN_W-1:0] prn);
        tap_pair_t t;
        case (prn)
            6'd1:    t = '{4'd2, 4'd6};
            6'd2:    t = '{4'd3, 4'd7};
            6'd3:    t = '{4'd4, 4'd8};
            6'd4:    t = '{4'd5, 4'd9};
            6'd5:    t = '{4'd1, 4'd9};
            6'd6:    t = '{4'd2, 4'd10};
            6'd7:    t = '{4'd1, 4'd8};
            6'd8:    t = '{4'd2, 4'd9};
            6'd9:    t = '{4'd3, 4'd10};
            6'd10:   t = '{4'd2, 4'd3};
            6'd11:   t = '{4'd3, 4'd4};
            6'd12:   t = '{4'd5, 4'd6};
            6'd13:   t = '{4'd6, 4'd7};
            6'd14:   t = '{4'd7, 4'd8};
            6'd15:   t = '{4'd8, 4'd9};
            6'd16:   t = '{4'd9, 4'd10};
            6'd17:   t = '{4'd1, 4'd4};
            6'd18:   t = '{4'd2, 4'd5};
            6'd19:   t = '{4'd3, 4'd6};
            6'd20:   t = '{4'd4, 4'd7};
            6'd21:   t = '{4'd5, 4'd8};
            6'd22:   t = '{4'd6, 4'd9};
            6'd23:   t = '{4'd1, 4'd3};
            6'd24:   t = '{4'd4, 4'd6};
            6'd25:   t = '{4'd5, 4'd7};
            6'd26:   t = '{4'd6, 4'd8};
            6'd27:   t = '{4'd7, 4'd9};
            6'd28:   t = '{4'd8, 4'd10};
            6'd29:   t = '{4'd1, 4'd6};
            6'd30:   t = '{4'd2, 4'd7};
            6'd31:   t = '{4'd3, 4'd8};
            6'd32:   t = '{4'd4, 4'd9};
            default: t = '{4'd2, 4'd6};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ca_lfsr_pair.sv
// G1/G2 C/A code LFSR pair with G2 phase-select tap mux.
// Ports: clk, rstn (sync, active-low), step (advance one chip),
//        reload (force both LFSRs to all ones, wins over step),
//        tap_sel (G2 tap pair used for the next chip), chip (registered code chip).
module ca_lfsr_pair
    import track_ca_generator_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      step,
    input  logic      reload,
    input  tap_pair_t tap_sel,
    output logic      chip
);

    logic [10:1] g1, g2;
    logic [10:1] g1_n, g2_n;
    logic [15:0] g2_ext;
    logic        chip_n;

    // Next LFSR state; chip is computed from it so the chip output is a flop.
    always_comb begin
        g1_n = g1;
        g2_n = g2;
        if (reload) begin
            g1_n = '1;
            g2_n = '1;
        end else if (step) begin
            g1_n = {g1[9:1], g1[3] ^ g1[10]};
            g2_n = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
        end
        // Zero-padded so any 4-bit tap index selects a defined bit.
        g2_ext = {5'd0, g2_n, 1'b0};
        chip_n = g1_n[10] ^ g2_ext[tap_sel.a] ^ g2_ext[tap_sel.b];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            g1   <= '1;
            g2   <= '1;
            chip <= 1'b1;  // all-ones state yields 1 for every tap pair
        end else begin
            g1   <= g1_n;
            g2   <= g2_n;
            chip <= chip_n;
        end
    end

endmodule

// File: rtl/track_ca_generator.sv
// GPS C/A code generator for a tracking channel: NCO-paced half-chip
// strobes drive early/prompt/late replicas spaced by half a chip.
// Ports: i_clk, i_rstn (sync, active-low), i_start/i_prn (load PRN and start),
//        i_code_rate (NCO increment, one wrap = half chip), i_en (sample strobe),
//        o_early/o_prompt/o_late (1 = +1), o_valid (i_en delayed), o_epoch,
//        o_chip_idx (prompt chip 0..1022), o_busy, o_err (illegal PRN on start).
module track_ca_generator
    import track_ca_generator_pkg::*;
#(
    parameter int unsigned NCO_WIDTH = 32,
    parameter int unsigned PRN_MAX   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [PRN_W-1:0]      i_prn,
    input  logic [NCO_WIDTH-1:0]  i_code_rate,
    input  logic                  i_en,
    output logic                  o_early,
    output logic                  o_prompt,
    output logic                  o_late,
    output logic                  o_valid,
    output logic                  o_epoch,
    output logic [CHIP_IDX_W-1:0] o_chip_idx,
    output logic                  o_busy,
    output logic                  o_err
);

    ca_state_t             state, next_state;
    logic [NCO_WIDTH-1:0]  nco, nco_n;
    logic [NCO_WIDTH:0]    nco_sum;
    logic                  pre_cnt;
    logic                  half;      // 1 when the next sample is the second half of a chip
    logic [CHIP_IDX_W-1:0] code_idx;  // chip currently presented by the LFSRs
    logic [CHIP_IDX_W-1:0] chip_idx;  // chip currently on the prompt output
    tap_pair_t             tap_q, tap_sel;
    logic                  early, prompt, late, valid, epoch, busy, err;
    logic                  prn_ok, load, shift, step, adv, reload, err_c;
    logic                  code_chip;

    assign prn_ok = (i_prn != '0) && (32'(i_prn) <= PRN_MAX);

    // Next-state and datapath control.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        nco_sum    = '0;
        nco_n      = nco;
        case (state)
            ST_IDLE: begin
                if (i_start && prn_ok) begin
                    load       = 1'b1;
                    next_state = ST_PRELOAD;
                end
            end
            ST_PRELOAD: begin
                // Two forced strobes put chip 0 on prompt before RUN.
                shift = 1'b1;
                if (pre_cnt) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (i_start && prn_ok) begin
                    load       = 1'b1;
                    next_state = ST_PRELOAD;
                end else if (i_en) begin
                    nco_sum = {1'b0, nco} + {1'b0, i_code_rate};
                    nco_n   = nco_sum[NCO_WIDTH-1:0];
                    shift   = nco_sum[NCO_WIDTH];
                end
            end
            default: next_state = ST_IDLE;
        endcase
        err_c   = i_start && !prn_ok && (state != ST_PRELOAD);
        // A strobe that completes a chip advances the LFSRs and, in RUN, the prompt index.
        step    = shift && half;
        adv     = step && (state == ST_RUN);
        reload  = load || (step && (code_idx == LAST_CHIP));
        tap_sel = load ? g2_tap_lookup(i_prn) : tap_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            nco      <= '0;
            pre_cnt  <= 1'b0;
            half     <= 1'b0;
            code_idx <= '0;
            chip_idx <= '0;
            tap_q    <= '{4'd2, 4'd6};
            early    <= 1'b0;
            prompt   <= 1'b0;
            late     <= 1'b0;
            valid    <= 1'b0;
            epoch    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= i_en;
            err   <= err_c;
            busy  <= (next_state != ST_IDLE);
            epoch <= 1'b0;
            if (load) begin
                tap_q    <= tap_sel;
                nco      <= '0;
                pre_cnt  <= 1'b0;
                half     <= 1'b0;
                code_idx <= '0;
                chip_idx <= '0;
                early    <= 1'b0;
                prompt   <= 1'b0;
                late     <= 1'b0;
            end else begin
                nco <= nco_n;
                if (state == ST_PRELOAD) pre_cnt <= ~pre_cnt;
                if (shift) begin
                    early  <= code_chip;
                    prompt <= early;
                    late   <= prompt;
                    half   <= ~half;
                end
                if (step) begin
                    code_idx <= (code_idx == LAST_CHIP) ? '0 : code_idx + 10'd1;
                end
                if (adv) begin
                    if (chip_idx == LAST_CHIP) begin
                        chip_idx <= '0;
                        epoch    <= 1'b1;
                    end else begin
                        chip_idx <= chip_idx + 10'd1;
                    end
                end
            end
        end
    end

    ca_lfsr_pair u_lfsr (
        .clk     (i_clk),
        .rstn    (i_rstn),
        .step    (step),
        .reload  (reload),
        .tap_sel (tap_sel),
        .chip    (code_chip)
    );

    assign o_early    = early;
    assign o_prompt   = prompt;
    assign o_late     = late;
    assign o_valid    = valid;
    assign o_epoch    = epoch;
    assign o_chip_idx = chip_idx;
    assign o_busy     = busy;
    assign o_err      = err;

endmodule

// File: tb/tb_track_ca_generator.sv
// Self-checking bench for track_ca_generator: reference model tracks the
// number of half-chip samples produced and derives E/P/L, index and epoch.
module tb_track_ca_generator;

    localparam int unsigned     NCO_W     = 32;
    localparam int unsigned     PRN_MAX   = 32;
    localparam longint unsigned PHASE_MOD = 64'd1 << NCO_W;
    localparam longint unsigned HALF      = 64'd1 << 31;

    logic       clk = 1'b0;
    logic       rstn, start, en;
    logic [5:0] prn;
    logic [NCO_W-1:0] rate;
    logic       early, prompt, late, valid, epoch, busy, err;
    logic [9:0] chip_idx;

    track_ca_generator #(.NCO_WIDTH(NCO_W), .PRN_MAX(PRN_MAX)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_prn       (prn),
        .i_code_rate (rate),
        .i_en        (en),
        .o_early     (early),
        .o_prompt    (prompt),
        .o_late      (late),
        .o_valid     (valid),
        .o_epoch     (epoch),
        .o_chip_idx  (chip_idx),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // IS-GPS-200 G2 phase-select pairs, PRN 1..32.
    int tap_a [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tap_b [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    bit              m_code [0:1022];
    int              m_mode = 0;   // 0 idle, 1 preload, 2 run
    int              m_pre  = 0;
    int              m_n    = 0;   // half-chip samples shifted since start
    longint unsigned m_phase = 0;
    bit              m_valid, m_err, m_epoch;

    // Full 1023-chip Gold code for one PRN.
    function automatic void gen_code(input int p);
        bit g1 [1:10];
        bit g2 [1:10];
        bit f1, f2;
        for (int i = 1; i <= 10; i++) begin g1[i] = 1'b1; g2[i] = 1'b1; end
        for (int k = 0; k < 1023; k++) begin
            m_code[k] = g1[10] ^ g2[tap_a[p]] ^ g2[tap_b[p]];
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            for (int i = 10; i > 1; i--) begin g1[i] = g1[i-1]; g2[i] = g2[i-1]; end
            g1[1] = f1;
            g2[1] = f2;
        end
    endfunction

    // Half-chip sample k is chip k/2; samples before the first are 0.
    function automatic bit smp(input int k);
        if (k < 0) return 1'b0;
        return m_code[(k / 2) % 1023];
    endfunction

    // One clock: drive inputs, advance model, compare every output.
    task automatic cycle(input bit r, input bit s, input int p, input longint unsigned rt, input bit e);
        bit legal;
        int exp_idx;
        rstn  = r;
        start = s;
        prn   = 6'(p);
        rate  = NCO_W'(rt);
        en    = e;
        @(posedge clk);
        #1;
        cyc++;
        m_valid = e;
        m_err   = 1'b0;
        m_epoch = 1'b0;
        legal   = (p >= 1) && (p <= int'(PRN_MAX));
        if (!r) begin
            m_mode  = 0;
            m_n     = 0;
            m_phase = 0;
            m_valid = 1'b0;
        end else begin
            if (s && !legal && m_mode != 1) m_err = 1'b1;
            if (m_mode == 1) begin
                m_n++;
                m_pre++;
                if (m_pre == 2) m_mode = 2;
            end else if (s && legal) begin
                m_mode  = 1;
                m_pre   = 0;
                m_n     = 0;
                m_phase = 0;
                gen_code(p);
            end else if (m_mode == 2 && e) begin
                m_phase += rt;
                if (m_phase >= PHASE_MOD) begin
                    m_phase -= PHASE_MOD;
                    m_n++;
                    if (m_n > 2 && (m_n - 2) % 2 == 0 && ((m_n - 2) / 2) % 1023 == 0) m_epoch = 1'b1;
                end
            end
        end
        exp_idx = (m_n >= 2) ? ((m_n - 2) / 2) % 1023 : 0;
        check_eq("epl", {29'd0, early, prompt, late}, {29'd0, smp(m_n - 1), smp(m_n - 2), smp(m_n - 3)});
        check_eq("ctl", {28'd0, valid, epoch, busy, err}, {28'd0, m_valid, m_epoch, (m_mode != 0), m_err});
        check_eq("chip_idx", {22'd0, chip_idx}, 32'(exp_idx));
    endtask

    // First ten prompt chips and chip duration at rate 2^31.
    task automatic first10(input int p, input logic [9:0] want);
        logic [9:0] word;
        int held, k;
        word = '0;
        held = 0;
        cycle(1, 1, p, HALF, 1);
        for (int i = 0; i < 44; i++) begin
            cycle(1, 0, 0, HALF, 1);
            k = int'(chip_idx);
            if (k < 10) word[9 - k] = prompt;
            if (k == 3) held++;
        end
        check_eq("first10", {22'd0, word}, {22'd0, want});
        check_eq("chip_len", 32'(held), 32'd4);
    endtask

    // Epoch spacing with i_en either held high or toggling.
    task automatic epoch_run(input bit toggle, input int spacing);
        int n_ep, first_at, gap;
        logic [9:0] prev;
        n_ep = 0; first_at = 0; gap = 0; prev = '0;
        cycle(1, 1, 1, HALF, 1);
        for (int i = 0; i < 2 * spacing + 64; i++) begin
            cycle(1, 0, 0, HALF, toggle ? (i % 2 == 0) : 1'b1);
            if (epoch) begin
                check_eq("epoch_wrap", {12'd0, prev, chip_idx}, {12'd0, 10'd1022, 10'd0});
                if (n_ep == 1) gap = cyc - first_at;
                else first_at = cyc;
                n_ep++;
            end
            prev = chip_idx;
        end
        check_eq("epoch_count", 32'(n_ep), 32'd2);
        check_eq("epoch_gap", 32'(gap), 32'(spacing));
    endtask

    initial begin
        bit r, s, e, found;
        int p;
        longint unsigned rt;
        logic [9:0] held_idx;

        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Illegal PRNs from IDLE.
        cycle(1, 1, 0, HALF, 1);
        check_eq("err_prn0", {30'd0, err, busy}, {30'd0, 2'b10});
        cycle(1, 0, 0, HALF, 1);
        check_eq("err_clear", {31'd0, err}, 32'd0);
        cycle(1, 1, 33, HALF, 1);
        check_eq("err_prn33", {30'd0, err, busy}, {30'd0, 2'b10});
        cycle(1, 0, 0, HALF, 1);

        first10(1, 10'o1440);
        first10(2, 10'o1620);

        epoch_run(1'b0, 4092);
        epoch_run(1'b1, 8184);

        // Zero rate stalls the code while o_valid tracks i_en.
        cycle(1, 1, 2, HALF, 1);
        repeat (10) cycle(1, 0, 0, HALF, 1);
        held_idx = chip_idx;
        for (int i = 0; i < 30; i++) begin
            cycle(1, 0, 0, 0, (i % 3) != 0);
            check_eq("stall_idx", {22'd0, chip_idx}, {22'd0, held_idx});
        end

        // Reset in the middle of RUN, then restart.
        cycle(1, 1, 1, HALF, 1);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            cycle(1, 0, 0, HALF, 1);
            if (chip_idx == 10'd500) found = 1'b1;
        end
        check_eq("reach_500", {31'd0, found}, 32'd1);
        cycle(0, 0, 0, HALF, 1);
        check_eq("rst_outs", {15'd0, early, prompt, late, valid, epoch, busy, err, chip_idx}, 32'd0);
        cycle(1, 0, 0, HALF, 1);
        cycle(1, 1, 1, HALF, 1);
        cycle(1, 0, 0, HALF, 1);
        cycle(1, 0, 0, HALF, 1);
        check_eq("restart", {21'd0, prompt, chip_idx}, {21'd0, 1'b1, 10'd0});

        // Randomized traffic: restarts, illegal PRNs, resets, rate changes.
        rt = HALF;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 39) == 0);
            p = int'($urandom_range(0, 40));
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 4))
                    0:       rt = 0;
                    1:       rt = HALF;
                    2:       rt = 64'($urandom);
                    3:       rt = 64'hFFFF_FFFF;
                    default: rt = 64'd1 << 30;
                endcase
            end
            cycle(r, s, p, rt, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
